// File: rtl/game_pkg.sv
// game_pkg: shared types, LFSR taps and BCD helper for the bomb game controller
package game_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, FAIL, WIN} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [7:0] sec_to_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction
endpackage

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: two-digit BCD down counter that saturates at 00
module bcd_down_counter
  import game_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] q,
  output logic       zero_next
);
  bcd_t       w_tens, w_ones;
  logic [7:0] w_dec_val;
  assign w_tens    = q[7:4];
  assign w_ones    = q[3:0];
  assign w_dec_val = (w_ones == 4'd0) ? {w_tens - 4'd1, 4'd9} : {w_tens, w_ones - 4'd1};
  assign zero_next = (q == 8'h01);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else if (load) q <= load_val;
    else if (dec && q != 8'h00) q <= w_dec_val;
  end
endmodule

// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl: arms the bomb, runs the seconds countdown and judges wire cuts
module bomb_game_ctrl
  import game_pkg::*;
#(
  parameter int         TICK_DIV  = 500,
  parameter int         START_SEC = 30,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] wire_in,
  input  logic       repeatRst,
  output logic       fail,
  output logic       success,
  output logic       armed,
  output logic [7:0] sec_bcd,
  output logic       beep_tick
);
  localparam logic [15:0] P_MAX   = 16'(TICK_DIV - 1);
  localparam logic [7:0]  START_V = sec_to_bcd(START_SEC);
  state_t      r_state, w_next;
  logic [15:0] r_presc;
  logic [7:0]  r_lfsr, r_wire_q, r_cut;
  logic [2:0]  r_target;
  logic [7:0]  w_tgt_mask, w_wrong;
  logic        w_wrap, w_arm, w_zero_next;
  assign w_wrap     = (r_state == ARMED) && (r_presc == P_MAX);
  assign w_arm      = (r_state == IDLE) && start && (wire_in == 8'hFF) && !repeatRst;
  assign w_tgt_mask = 8'b1 << r_target;
  assign w_wrong    = r_cut & ~w_tgt_mask;
  bcd_down_counter #(.RST_VAL(START_V)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_arm),
    .load_val (START_V),
    .dec      (w_wrap),
    .q        (sec_bcd),
    .zero_next(w_zero_next)
  );
  // a wrong cut or expiry wins over a simultaneous right cut
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_arm ? ARMED : IDLE;
      ARMED:   w_next = ((w_wrap && w_zero_next) || |w_wrong) ? FAIL :
                        (r_cut == w_tgt_mask) ? WIN : ARMED;
      FAIL:    w_next = repeatRst ? IDLE : FAIL;
      WIN:     w_next = start ? IDLE : WIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_lfsr    <= LFSR_SEED;
      r_wire_q  <= 8'hFF;
      r_cut     <= '0;
      r_target  <= '0;
      fail      <= 1'b0;
      success   <= 1'b0;
      armed     <= 1'b0;
      beep_tick <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_presc   <= (r_state == ARMED && !w_wrap) ? r_presc + 16'd1 : '0;
      r_lfsr    <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
      r_wire_q  <= wire_in;
      r_cut     <= r_wire_q & ~wire_in;
      r_target  <= w_arm ? r_lfsr[2:0] : r_target;
      fail      <= (w_next == FAIL);
      success   <= (w_next == WIN);
      armed     <= (w_next == ARMED);
      beep_tick <= w_wrap;
    end
  end
endmodule

// File: tb/tb_bomb_game_ctrl.sv
// tb_bomb_game_ctrl: directed checks of arming, countdown, cut judging and reset
module tb_bomb_game_ctrl;
  logic       clk, rst_n, start, repeatRst;
  logic [7:0] wire_in;
  logic       fail, success, armed, beep_tick;
  logic [7:0] sec_bcd;
  logic       fail20, success20, armed20, beep20;
  logic [7:0] sec20;
  logic [7:0] m_lfsr;
  logic [2:0] tgt, other;
  int         n_vec, n_err;

  bomb_game_ctrl #(.TICK_DIV(4), .START_SEC(3), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wire_in(wire_in), .repeatRst(repeatRst),
    .fail(fail), .success(success), .armed(armed), .sec_bcd(sec_bcd), .beep_tick(beep_tick)
  );
  bomb_game_ctrl #(.TICK_DIV(4), .START_SEC(20), .LFSR_SEED(8'hA5)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .wire_in(wire_in), .repeatRst(repeatRst),
    .fail(fail20), .success(success20), .armed(armed20), .sec_bcd(sec20), .beep_tick(beep20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x^8+x^6+x^5+x^4+1 Fibonacci reference, used only to know the target wire
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; repeatRst = 1'b0; wire_in = 8'hFF;
    #12;
    chk1("rst_fail", fail, 1'b0);
    chk1("rst_success", success, 1'b0);
    chk1("rst_armed", armed, 1'b0);
    chk1("rst_beep", beep_tick, 1'b0);
    chk8("rst_sec", sec_bcd, 8'h03);
    chk8("rst_sec20", sec20, 8'h20);
    rst_n = 1'b1;
    step(1);
    // countdown to expiry
    start = 1'b1; step(1); start = 1'b0;
    chk1("arm_armed", armed, 1'b1);
    chk8("arm_sec", sec_bcd, 8'h03);
    step(3);
    chk1("pre_tick_beep", beep_tick, 1'b0);
    chk8("pre_tick_sec", sec_bcd, 8'h03);
    step(1);
    chk1("tick1_beep", beep_tick, 1'b1);
    chk8("tick1_sec", sec_bcd, 8'h02);
    chk8("tick1_sec20_borrow", sec20, 8'h19);
    step(1);
    chk1("tick1_beep_drop", beep_tick, 1'b0);
    step(3);
    chk8("tick2_sec", sec_bcd, 8'h01);
    chk1("tick2_beep", beep_tick, 1'b1);
    step(4);
    chk8("expire_sec", sec_bcd, 8'h00);
    chk1("expire_fail", fail, 1'b1);
    chk1("expire_armed", armed, 1'b0);
    step(3);
    chk8("fail_frozen_sec", sec_bcd, 8'h00);
    // repeatRst held high blocks re-arming
    repeatRst = 1'b1; start = 1'b1; step(1);
    chk1("rep_fail_drop", fail, 1'b0);
    chk1("rep_armed", armed, 1'b0);
    step(2);
    chk1("rep_start_ignored", armed, 1'b0);
    start = 1'b0; repeatRst = 1'b0; step(1);
    // right cut wins
    tgt = m_lfsr[2:0];
    start = 1'b1; step(1); start = 1'b0;
    chk1("rearm_armed", armed, 1'b1);
    chk8("rearm_sec", sec_bcd, 8'h03);
    wire_in = ~(8'b1 << tgt); step(1);
    chk1("cut_lat1_success", success, 1'b0);
    step(1);
    chk1("cut_success", success, 1'b1);
    chk1("cut_armed", armed, 1'b0);
    wire_in = 8'hFF; step(5);
    chk1("win_hold", success, 1'b1);
    chk8("win_frozen_sec", sec_bcd, 8'h03);
    start = 1'b1; step(1); start = 1'b0;
    chk1("win_exit_success", success, 1'b0);
    chk1("win_exit_armed", armed, 1'b0);
    step(1);
    // right and wrong cut together
    tgt = m_lfsr[2:0]; other = tgt ^ 3'd4;
    start = 1'b1; step(1); start = 1'b0;
    wire_in = ~((8'b1 << tgt) | (8'b1 << other)); step(2);
    chk1("dual_fail", fail, 1'b1);
    chk1("dual_success", success, 1'b0);
    repeatRst = 1'b1; wire_in = 8'hFF; step(1); repeatRst = 1'b0; step(1);
    chk1("dual_cleared", fail, 1'b0);
    // right cut lands on the expiry cycle
    tgt = m_lfsr[2:0];
    start = 1'b1; step(1); start = 1'b0;
    step(10);
    wire_in = ~(8'b1 << tgt); step(2);
    chk1("late_cut_fail", fail, 1'b1);
    chk1("late_cut_success", success, 1'b0);
    chk8("late_cut_sec", sec_bcd, 8'h00);
    repeatRst = 1'b1; wire_in = 8'hFF; step(1); repeatRst = 1'b0; step(1);
    // asynchronous reset mid-count
    start = 1'b1; step(1); start = 1'b0;
    step(5);
    chk8("mid_sec", sec_bcd, 8'h02);
    #2 rst_n = 1'b0; #1;
    chk1("async_armed", armed, 1'b0);
    chk8("async_sec", sec_bcd, 8'h03);
    chk1("async_beep", beep_tick, 1'b0);
    chk1("async_fail", fail, 1'b0);
    rst_n = 1'b1; wire_in = 8'hFE; start = 1'b1; step(1); start = 1'b0;
    chk1("cut_start_ignored", armed, 1'b0);
    step(1);
    chk1("cut_start_idle", armed, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
